// File: rtl/prog_loader.sv
// prog_loader: streams a program image into mem at BASE_ADDR while holding the core in reset,
// then releases core reset and pulses trigger. Define PROG_LOADER_VERIFY_EN for readback checksum verify.
module prog_loader #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  core_reset_n,
    output logic                  trigger,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
`ifdef PROG_LOADER_VERIFY_EN
        S_VERIFY  = 3'd2,
`endif
        S_RELEASE = 3'd3,
        S_TRIG    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] len_q, cnt;
    logic                  core_rn_q;
    logic                  accept, beat, last_beat;

    assign accept       = start && (state == S_IDLE || state == S_DONE);
    assign s_ready      = (state == S_WRITE);
    assign beat         = s_valid && s_ready;
    assign last_beat    = beat && (cnt == len_q - ADDR_WIDTH'(1));
    assign busy         = !(state == S_IDLE || state == S_DONE);
    assign done         = (state == S_DONE);
    assign trigger      = (state == S_TRIG);
    assign core_reset_n = core_rn_q;

`ifdef PROG_LOADER_VERIFY_EN
    logic [DATA_WIDTH-1:0] sum_w, sum_r, sum_next;
    logic [ADDR_WIDTH:0]   vcnt;
    logic                  verify_last, sum_ok, error_q;

    // Read data for address k arrives in verify cycle k+2, so the last one lands at cycle length+1.
    assign sum_next    = sum_r + mem_dout;
    assign verify_last = (state == S_VERIFY) && (vcnt == {1'b0, len_q} + (ADDR_WIDTH+1)'(1));
    assign sum_ok      = (sum_next == sum_w);
    assign error       = error_q;
`else
    logic unused_dout;
    assign unused_dout = ^mem_dout;
    assign error       = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = (length == '0) ? S_RELEASE : S_WRITE;
`ifdef PROG_LOADER_VERIFY_EN
            S_WRITE:        if (last_beat) next_state = S_VERIFY;
            S_VERIFY:       if (verify_last) next_state = sum_ok ? S_RELEASE : S_DONE;
`else
            S_WRITE:        if (last_beat) next_state = S_RELEASE;
`endif
            S_RELEASE:      next_state = S_TRIG;
            S_TRIG:         next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            core_rn_q <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            state  <= next_state;
            mem_we <= beat;
            if (accept) begin
                len_q     <= length;
                cnt       <= '0;
                core_rn_q <= 1'b0;
            end
            if (beat) begin
                mem_addr <= BASE_ADDR + cnt;
                mem_din  <= s_data;
                cnt      <= cnt + ADDR_WIDTH'(1);
            end
            // Entering RELEASE overrides the accept-clear so a zero-length start releases at once.
            if (next_state == S_RELEASE) core_rn_q <= 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
            if (state == S_VERIFY && vcnt < {1'b0, len_q})
                mem_addr <= BASE_ADDR + vcnt[ADDR_WIDTH-1:0];
`endif
        end
    end

`ifdef PROG_LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            sum_w   <= '0;
            sum_r   <= '0;
            vcnt    <= '0;
            error_q <= 1'b0;
        end else begin
            if (beat) sum_w <= sum_w + s_data;
            if (state == S_VERIFY) begin
                vcnt <= vcnt + (ADDR_WIDTH+1)'(1);
                if (vcnt >= (ADDR_WIDTH+1)'(2)) sum_r <= sum_next;
                if (verify_last && !sum_ok) error_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads with a write scoreboard, plus
// hand sequences for reset mid-load, zero length, start-while-busy and address wrap.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam logic [15:0] BASE  = 16'h0200;
    localparam logic [15:0] WBASE = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset, start, s_valid;
    logic [15:0] length;
    logic [7:0]  s_data;
    logic        s_ready, mem_we, core_reset_n, trigger, busy, done, error;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;

    logic        w_start, w_s_valid;
    logic [15:0] w_length;
    logic [7:0]  w_s_data;
    logic        w_s_ready, w_mem_we, w_core_reset_n, w_trigger, w_busy, w_done, w_error;
    logic [15:0] w_mem_addr;
    logic [7:0]  w_mem_din, w_mem_dout;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .core_reset_n(core_reset_n), .trigger(trigger), .busy(busy), .done(done), .error(error)
    );

    prog_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(WBASE)) dut_wrap (
        .clk(clk), .reset(reset), .start(w_start), .length(w_length),
        .s_valid(w_s_valid), .s_data(w_s_data), .s_ready(w_s_ready),
        .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_din(w_mem_din), .mem_dout(w_mem_dout),
        .core_reset_n(w_core_reset_n), .trigger(w_trigger), .busy(w_busy), .done(w_done),
        .error(w_error)
    );

    // Memory models: synchronous write, one-clock read latency. corrupt replaces byte 0201 with 06.
    logic [7:0] mem  [0:65535];
    logic [7:0] wmem [0:65535];
    logic       corrupt = 1'b0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= (corrupt && mem_addr == 16'h0201) ? 8'h06 : mem_din;
        mem_dout <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (w_mem_we) wmem[w_mem_addr] <= w_mem_din;
        w_mem_dout <= wmem[w_mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkv(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t exp_q[$];
    bit  pend = 1'b0;

    // Advance to the next falling edge and score the main DUT's write port.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (pend) begin
            if (exp_q.size() == 0) begin
                check1("scoreboard_empty", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check1("mem_we_beat", mem_we, 1'b1);
                checkv("mem_addr", mem_addr, e.addr);
                checkv("mem_din", 16'(mem_din), 16'(e.data));
            end
            pend = 1'b0;
        end else begin
            check1("mem_we_quiet", mem_we, 1'b0);
        end
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
        pend = 1'b1;
    endtask

    typedef struct {
        logic [15:0]     len;
        logic [3:0][7:0] bytes;
        bit              gapped;
        bit              poke;
        bit              corrupt;
        bit              exp_error;
    } case_t;
    case_t cases [4];
    int    ncases;

    task automatic set_case(input int i, input logic [15:0] len, input logic [31:0] b,
                            input bit gapped, input bit poke, input bit corr, input bit err);
        cases[i].len       = len;
        cases[i].bytes     = b;
        cases[i].gapped    = gapped;
        cases[i].poke      = poke;
        cases[i].corrupt   = corr;
        cases[i].exp_error = err;
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_s_ready"}, s_ready, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        checkv({tag, "_mem_addr"}, mem_addr, 16'h0000);
        checkv({tag, "_mem_din"}, 16'(mem_din), 16'h0000);
        check1({tag, "_core_reset_n"}, core_reset_n, 1'b0);
        check1({tag, "_trigger"}, trigger, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t       tc;
        int          idx, cyc;
        logic [7:0]  wbytes [3];
        logic [15:0] waddrs [3];

        set_case(0, 16'd4, 32'h03_69_05_A9, 1'b0, 1'b0, 1'b0, 1'b0);
        set_case(1, 16'd4, 32'h03_69_05_A9, 1'b1, 1'b1, 1'b0, 1'b0);
        set_case(2, 16'd1, 32'h00_00_00_5A, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PROG_LOADER_VERIFY_EN
        set_case(3, 16'd4, 32'h03_69_05_A9, 1'b0, 1'b0, 1'b1, 1'b1);
        ncases = 4;
`else
        ncases = 3;
`endif

        reset = 1'b1; start = 1'b0; length = '0; s_valid = 1'b0; s_data = '0;
        w_start = 1'b0; w_length = '0; w_s_valid = 1'b0; w_s_data = '0;
        tick();
        tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();
        check_reset_values("idle");

        for (int c = 0; c < ncases; c++) begin
            tc = cases[c];
            corrupt = tc.corrupt;
            start = 1'b1;
            length = tc.len;
            tick();
            start = 1'b0;
            check1("busy_after_start", busy, 1'b1);
            check1("done_cleared", done, 1'b0);
            check1("error_cleared", error, 1'b0);
            check1("core_reset_n_load", core_reset_n, 1'b0);
            idx = 0;
            cyc = 0;
            while (idx < int'(tc.len) && cyc < 64) begin
                check1("s_ready_write", s_ready, 1'b1);
                s_valid = !tc.gapped || (cyc % 2 == 0);
                s_data  = s_valid ? tc.bytes[idx] : 8'hEE;
                start   = tc.poke && (cyc == 1);
                length  = start ? 16'd9 : tc.len;
                if (s_valid) begin
                    push_write(BASE + 16'(idx), tc.bytes[idx]);
                    idx++;
                end
                tick();
                cyc++;
            end
            start = 1'b0;
            checkv("beats_accepted", 16'(idx), tc.len);
            check1("s_ready_drop", s_ready, 1'b0);
            s_valid = 1'b1;
            s_data  = 8'hEE;
`ifdef PROG_LOADER_VERIFY_EN
            for (int k = 0; k < int'(tc.len) + 2; k++) begin
                check1("verify_busy", busy, 1'b1);
                check1("verify_core_reset_n", core_reset_n, 1'b0);
                check1("verify_trigger", trigger, 1'b0);
                tick();
                s_valid = 1'b0;
            end
`endif
            if (tc.exp_error) begin
                check1("err_done", done, 1'b1);
                check1("err_error", error, 1'b1);
                check1("err_core_reset_n", core_reset_n, 1'b0);
                check1("err_busy", busy, 1'b0);
                tick();
                check1("err_no_trigger", trigger, 1'b0);
                check1("err_error_held", error, 1'b1);
                check1("err_core_reset_n_held", core_reset_n, 1'b0);
            end else begin
                check1("release_core_reset_n", core_reset_n, 1'b1);
                check1("release_trigger", trigger, 1'b0);
                check1("release_busy", busy, 1'b1);
                tick();
                s_valid = 1'b0;
                check1("trig_pulse", trigger, 1'b1);
                check1("trig_core_reset_n", core_reset_n, 1'b1);
                tick();
                check1("done_trigger_low", trigger, 1'b0);
                check1("done_set", done, 1'b1);
                check1("done_error", error, 1'b0);
                check1("done_busy", busy, 1'b0);
                check1("done_core_reset_n", core_reset_n, 1'b1);
                for (int i = 0; i < int'(tc.len); i++)
                    checkv("mem_image", 16'(mem[BASE + 16'(i)]), 16'(tc.bytes[i]));
            end
            s_valid = 1'b0;
            corrupt = 1'b0;
        end

        // Zero length: straight to RELEASE; a start during RELEASE is ignored.
        start = 1'b1;
        length = 16'd0;
        tick();
        length = 16'd5;
        check1("len0_core_reset_n", core_reset_n, 1'b1);
        check1("len0_trigger_early", trigger, 1'b0);
        check1("len0_busy", busy, 1'b1);
        check1("len0_error", error, 1'b0);
        tick();
        start = 1'b0;
        check1("len0_trigger", trigger, 1'b1);
        tick();
        check1("len0_trigger_off", trigger, 1'b0);
        check1("len0_done", done, 1'b1);
        tick();
        check1("busy_start_ignored_done", done, 1'b1);
        check1("busy_start_ignored_busy", busy, 1'b0);
        check1("busy_start_ignored_ready", s_ready, 1'b0);

        // Reset held three clocks in the middle of a load.
        start = 1'b1;
        length = 16'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h40 + 8'(i);
            push_write(BASE + 16'(i), s_data);
            tick();
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_reset_values("midreset");
        end
        reset = 1'b0;
        s_valid = 1'b0;
        tick();
        check1("post_reset_idle_busy", busy, 1'b0);
        check1("post_reset_idle_ready", s_ready, 1'b0);

        // Address wrap on the FFFE-based instance.
        wbytes = '{8'h11, 8'h22, 8'h33};
        waddrs = '{16'hFFFE, 16'hFFFF, 16'h0000};
        w_start = 1'b1;
        w_length = 16'd3;
        tick();
        w_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("wrap_s_ready", w_s_ready, 1'b1);
            w_s_valid = 1'b1;
            w_s_data  = wbytes[i];
            tick();
            check1("wrap_mem_we", w_mem_we, 1'b1);
            checkv("wrap_mem_addr", w_mem_addr, waddrs[i]);
            checkv("wrap_mem_din", 16'(w_mem_din), 16'(wbytes[i]));
        end
        w_s_valid = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
        for (int k = 0; k < 5; k++) tick();
`endif
        check1("wrap_core_reset_n", w_core_reset_n, 1'b1);
        tick();
        check1("wrap_trigger", w_trigger, 1'b1);
        tick();
        check1("wrap_done", w_done, 1'b1);
        check1("wrap_error", w_error, 1'b0);
        for (int i = 0; i < 3; i++)
            checkv("wrap_mem_image", 16'(wmem[waddrs[i]]), 16'(wbytes[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
